// File: rtl/life_ctrl.sv
// Game life/phase controller: sequences idle, ready freeze, play, death freeze
// and game-over, tracking remaining lives and issuing a respawn pulse.
module life_ctrl #(
  parameter int unsigned LIVES_INIT  = 3,
  parameter int unsigned READY_TICKS = 60,
  parameter int unsigned DEATH_TICKS = 90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start_btn,
  input  logic       p_dead,
  output logic [1:0] lives,
  output logic [2:0] state,
  output logic       freeze,
  output logic       respawn,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_PLAY  = 3'd2,
    S_DYING = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  localparam logic [1:0] LIVES_LOAD = 2'(LIVES_INIT);
  localparam logic [7:0] READY_LOAD = 8'(READY_TICKS);
  localparam logic [7:0] DEATH_LOAD = 8'(DEATH_TICKS);

  state_e     state_q, state_d;
  logic [1:0] lives_q, lives_d;
  logic [7:0] timer_q, timer_d;
  logic       start_prev_q;
  logic       freeze_q, freeze_d;
  logic       respawn_q, respawn_d;
  logic       game_over_q, game_over_d;
  logic       start_edge;

  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    timer_d    = timer_q;
    start_edge = start_btn & ~start_prev_q;
    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          state_d = S_READY;
          lives_d = LIVES_LOAD;
          timer_d = READY_LOAD;
        end
      end
      S_READY: begin
        if (tick) begin
          timer_d = timer_q - 8'd1;
          if (timer_q == 8'd1) state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        // Death wins over tick: the timer is loaded, never decremented, here.
        if (p_dead) begin
          state_d = S_DYING;
          lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
          timer_d = DEATH_LOAD;
        end
      end
      S_DYING: begin
        if (tick) begin
          timer_d = timer_q - 8'd1;
          if (timer_q == 8'd1) begin
            if (lives_q == 2'd0) begin
              state_d = S_OVER;
            end else begin
              state_d = S_READY;
              timer_d = READY_LOAD;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered from the next-state values so they align with state.
    respawn_d   = (state_d == S_READY) && (state_q != S_READY);
    freeze_d    = (state_d != S_PLAY);
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lives_q      <= LIVES_LOAD;
      timer_q      <= '0;
      start_prev_q <= 1'b1;
      freeze_q     <= 1'b1;
      respawn_q    <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      timer_q      <= timer_d;
      start_prev_q <= start_btn;
      freeze_q     <= freeze_d;
      respawn_q    <= respawn_d;
      game_over_q  <= game_over_d;
    end
  end

  assign lives     = lives_q;
  assign state     = state_q;
  assign freeze    = freeze_q;
  assign respawn   = respawn_q;
  assign game_over = game_over_q;

endmodule
